// File: rtl/mod_updown_counter.sv
// Purpose: synchronous up/down counter with enable, load, arbitrary modulus and wrap/saturate ends.
// Latency: Q and wrap update on the rising clock edge after the controls are sampled; at_max/at_zero decode Q combinationally.
// Backpressure: none; every edge is accepted, and clear > load > enable sets the priority.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    // Highest legal count; arithmetic wraps here rather than at 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    // Out-of-range load values are pinned to the top of the range so Q stays legal.
    always_comb begin
        load_clamped = load_value;
        if (load_value > MAX_VAL) begin
            load_clamped = MAX_VAL;
        end
    end

    // Next count and terminal-event flag; load beats counting, idle holds and clears wrap.
    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = load_clamped;
        end else if (enable) begin
            if (up_down) begin
                if (Q == MAX_VAL) begin
                    wrap_next = 1'b1;
                    q_next    = SATURATE ? Q : '0;
                end else begin
                    q_next = Q + 1'b1;
                end
            end else begin
                if (Q == '0) begin
                    wrap_next = 1'b1;
                    q_next    = SATURATE ? Q : MAX_VAL;
                end else begin
                    q_next = Q - 1'b1;
                end
            end
        end
    end

    // Single-edge state register; clear is synchronous and overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
        end
    end

    assign at_max  = (Q == MAX_VAL);
    assign at_zero = (Q == '0);

endmodule
